tone_gen_multi: RTL and testbench



---
 rtl/tone_pkg.sv | 34 +++
 rtl/tone_gen_multi_channel.sv | 94 +++++++++
 rtl/tone_gen_multi.sv | 128 ++++++++++++
 tb/tb_tone_gen_multi.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants, types and helpers for the multi-channel tone generator.
//   VOL_W        : width of the volume level
//   GAIN_W       : width of the per-channel click-suppression gain
//   GAIN_FULL    : gain value of a fully ramped-up note
//   REST_DIV_MIN : smallest note divisor that actually plays
//   vol_cmd_e    : decoded button command for the volume register
//   amp_of()     : volume level to peak amplitude
package tone_pkg;

    localparam int unsigned VOL_W        = 3;
    localparam int unsigned GAIN_W       = 8;
    localparam logic [GAIN_W-1:0] GAIN_FULL = 8'd255;
    localparam int unsigned REST_DIV_MIN = 2;

    typedef enum logic [1:0] {
        VolHold,
        VolUp,
        VolDown
    } vol_cmd_e;

    // Each volume step below the top level halves the amplitude; level 0 mutes.
    // The top level leaves two bits of headroom under full scale.
    function automatic logic [31:0] amp_of(input logic [VOL_W-1:0] vol,
                                           input int unsigned      aud_w,
                                           input int unsigned      vol_max);
        logic [31:0] full;
        full = 32'd1 << (aud_w - 2);
        if (vol == '0) begin
            return '0;
        end
        return full >> (vol_max - 32'(vol));
    endfunction

endpackage

// File: rtl/tone_gen_multi_channel.sv
// One tone channel: note divider with retrigger, linear gain ramp and
// registered signed sample.
//   clk, rst       : clock, asynchronous active-high reset
//   div_i          : note divisor; 0 or 1 means rest
//   amp_i          : peak amplitude for the current volume (non-negative)
//   ramp_pulse_i   : one-cycle strobe that moves the gain one step
//   sample_o       : signed square-wave sample, registered
module tone_channel
    import tone_pkg::*;
#(
    parameter int unsigned DIV_W = 22,
    parameter int unsigned AUD_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIV_W-1:0]        div_i,
    input  logic [AUD_W-1:0]        amp_i,
    input  logic                    ramp_pulse_i,
    output logic signed [AUD_W-1:0] sample_o
);

    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [DIV_W-1:0]        prev_div_q;
    logic                    phase_q, phase_d;
    logic [GAIN_W-1:0]       gain_q, gain_d;
    logic [GAIN_W-1:0]       gain_target;
    logic signed [AUD_W-1:0] sample_q, sample_d;
    logic signed [AUD_W:0]   amp_s;
    logic signed [AUD_W+GAIN_W-1:0] prod;
    logic                    playing;
    logic                    unused_prod_lsb;

    assign playing = (div_i >= DIV_W'(REST_DIV_MIN));

    // Divider. A divisor change restarts the waveform from the positive half,
    // including a change into rest, after which the phase stays frozen.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (div_i != prev_div_q) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (playing) begin
            if (cnt_q == div_i) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Gain only follows play/rest, so note-to-note changes keep full gain.
    assign gain_target = playing ? GAIN_FULL : '0;

    always_comb begin
        gain_d = gain_q;
        if (ramp_pulse_i) begin
            if (gain_q < gain_target) begin
                gain_d = gain_q + 1'b1;
            end else if (gain_q > gain_target) begin
                gain_d = gain_q - 1'b1;
            end
        end
    end

    // Product fits in AUD_W+GAIN_W signed bits because amp is at most 2^(AUD_W-2).
    always_comb begin
        amp_s    = phase_q ? -$signed({1'b0, amp_i}) : $signed({1'b0, amp_i});
        prod     = amp_s * $signed({1'b0, gain_q});
        sample_d = prod[AUD_W+GAIN_W-1:GAIN_W];
    end

    assign unused_prod_lsb = ^prod[GAIN_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            prev_div_q <= '0;
            phase_q    <= 1'b0;
            gain_q     <= '0;
            sample_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            prev_div_q <= div_i;
            phase_q    <= phase_d;
            gain_q     <= gain_d;
            sample_q   <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave tone generator with shared button-stepped volume,
// per-channel click-free gain ramp and a saturating mono mix.
//   clk, rst     : clock, asynchronous active-high reset
//   volume_up    : debounced level input, one step per rising edge
//   volume_down  : debounced level input, one step per rising edge
//   note_div     : per-channel divisor, channel c at [c*DIV_W +: DIV_W]
//   audio_ch     : per-channel signed sample, channel c at [c*AUD_W +: AUD_W]
//   audio_mix    : saturated sum of all channels, one cycle behind audio_ch
//   volume       : current volume level, 0 = mute
module tone_gen_multi
    import tone_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DIV_W    = 22,
    parameter int unsigned AUD_W    = 16,
    parameter int unsigned VOL_MAX  = 5,
    parameter int unsigned VOL_INIT = 3,
    parameter int unsigned RAMP_DIV = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      volume_up,
    input  logic                      volume_down,
    input  logic [NUM_CH*DIV_W-1:0]   note_div,
    output logic [NUM_CH*AUD_W-1:0]   audio_ch,
    output logic [AUD_W-1:0]          audio_mix,
    output logic [VOL_W-1:0]          volume
);

    localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned SUM_W = AUD_W + 3;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic signed [SUM_W-1:0] MIX_MAX = {4'b0000, {(AUD_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIX_MIN = {4'b1111, {(AUD_W-1){1'b0}}};

    // ---------------- volume ----------------
    logic             up_q, down_q;
    logic             up_evt, down_evt;
    vol_cmd_e         vol_cmd;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic [AUD_W-1:0] amp;

    assign up_evt   = volume_up & ~up_q;
    assign down_evt = volume_down & ~down_q;

    always_comb begin
        vol_cmd = VolHold;
        if (up_evt && !down_evt) begin
            vol_cmd = VolUp;
        end else if (down_evt && !up_evt) begin
            vol_cmd = VolDown;
        end
    end

    always_comb begin
        vol_d = vol_q;
        case (vol_cmd)
            VolUp:   if (vol_q < VOL_W'(VOL_MAX)) vol_d = vol_q + 1'b1;
            VolDown: if (vol_q != '0) vol_d = vol_q - 1'b1;
            default: vol_d = vol_q;
        endcase
    end

    assign amp = AUD_W'(amp_of(vol_q, AUD_W, VOL_MAX));

    // ---------------- ramp prescaler ----------------
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             ramp_pulse;

    assign ramp_pulse = (pre_q == PRE_LAST);
    assign pre_d      = ramp_pulse ? '0 : pre_q + 1'b1;

    // ---------------- channels ----------------
    logic signed [AUD_W-1:0] ch_sample [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tone_channel #(
            .DIV_W (DIV_W),
            .AUD_W (AUD_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .div_i        (note_div[c*DIV_W +: DIV_W]),
            .amp_i        (amp),
            .ramp_pulse_i (ramp_pulse),
            .sample_o     (ch_sample[c])
        );
        assign audio_ch[c*AUD_W +: AUD_W] = ch_sample[c];
    end

    // ---------------- mixer ----------------
    logic signed [SUM_W-1:0] sum;
    logic [AUD_W-1:0]        mix_q, mix_d;

    always_comb begin
        sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum = sum + SUM_W'(ch_sample[c]);
        end
        if (sum > MIX_MAX) begin
            mix_d = {1'b0, {(AUD_W-1){1'b1}}};
        end else if (sum < MIX_MIN) begin
            mix_d = {1'b1, {(AUD_W-1){1'b0}}};
        end else begin
            mix_d = sum[AUD_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            vol_q  <= VOL_W'(VOL_INIT);
            pre_q  <= '0;
            mix_q  <= '0;
        end else begin
            up_q   <= volume_up;
            down_q <= volume_down;
            vol_q  <= vol_d;
            pre_q  <= pre_d;
            mix_q  <= mix_d;
        end
    end

    assign audio_mix = mix_q;
    assign volume    = vol_q;

endmodule

// File: tb/tb_tone_gen_multi.sv
// Directed bench for tone_gen_multi: 4 channels, ramp step every clock.
module tb_tone_gen_multi;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned DIV_W    = 22;
    localparam int unsigned AUD_W    = 16;
    localparam int unsigned VOL_MAX  = 5;
    localparam int unsigned VOL_INIT = 3;
    localparam int unsigned RAMP_DIV = 1;

    logic                    clk;
    logic                    rst;
    logic                    volume_up;
    logic                    volume_down;
    logic [NUM_CH*DIV_W-1:0] note_div;
    logic [NUM_CH*AUD_W-1:0] audio_ch;
    logic [AUD_W-1:0]        audio_mix;
    logic [2:0]              volume;

    int n_cmp;
    int n_fail;

    tone_gen_multi #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .AUD_W    (AUD_W),
        .VOL_MAX  (VOL_MAX),
        .VOL_INIT (VOL_INIT),
        .RAMP_DIV (RAMP_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .volume_up   (volume_up),
        .volume_down (volume_down),
        .note_div    (note_div),
        .audio_ch    (audio_ch),
        .audio_mix   (audio_mix),
        .volume      (volume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [31:0] ch_s(input int c);
        logic [AUD_W-1:0] v;
        v = audio_ch[c*AUD_W +: AUD_W];
        return {{(32-AUD_W){v[AUD_W-1]}}, v};
    endfunction

    function automatic logic signed [31:0] mix_s();
        return {{(32-AUD_W){audio_mix[AUD_W-1]}}, audio_mix};
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_div(input int c, input int unsigned v);
        note_div[c*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic pulse_up();
        volume_up = 1'b1;
        step(1);
        volume_up = 1'b0;
        step(2);
    endtask

    task automatic pulse_down();
        volume_down = 1'b1;
        step(1);
        volume_down = 1'b0;
        step(2);
    endtask

    int up_exp[4];
    int dn_exp[6];
    logic signed [31:0] mag;

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        rst         = 1'b0;
        volume_up   = 1'b0;
        volume_down = 1'b0;
        note_div    = '0;
        up_exp      = '{4, 5, 5, 5};
        dn_exp      = '{4, 3, 2, 1, 0, 0};

        // Reset state, before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_volume", 32'(volume), 3);
        chk("rst_ch0", ch_s(0), 0);
        chk("rst_ch3", ch_s(3), 0);
        chk("rst_mix", mix_s(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Volume range
        for (int i = 0; i < 4; i++) begin
            pulse_up();
            chk("vol_up", 32'(volume), up_exp[i]);
        end
        for (int i = 0; i < 6; i++) begin
            pulse_down();
            chk("vol_down", 32'(volume), dn_exp[i]);
        end
        volume_up = 1'b1;
        step(50);
        chk("vol_hold", 32'(volume), 1);
        volume_up = 1'b0;
        step(2);
        chk("vol_hold_rel", 32'(volume), 1);
        for (int i = 0; i < 4; i++) pulse_up();
        chk("vol_back_max", 32'(volume), 5);
        volume_up   = 1'b1;
        volume_down = 1'b1;
        step(1);
        chk("vol_both", 32'(volume), 5);
        volume_up   = 1'b0;
        volume_down = 1'b0;
        step(2);
        chk("vol_both_rel", 32'(volume), 5);
        chk("idle_ch0", ch_s(0), 0);

        // ch0 div=9 at volume 5: sample = +/-64*gain, gain counts 1 per cycle
        set_div(0, 9);
        step(1);   chk("div_k1", ch_s(0), 0);
        step(1);   chk("div_k2", ch_s(0), 64);
        step(9);   chk("div_k11", ch_s(0), 640);
        step(1);   chk("div_k12", ch_s(0), -704);
        chk("mix_k12", mix_s(), 640);
        step(9);   chk("div_k21", ch_s(0), -1280);
        step(1);   chk("div_k22", ch_s(0), 1344);
        step(234); chk("div_k256", ch_s(0), -16320);
        step(5);   chk("div_k261", ch_s(0), -16320);
        step(1);   chk("div_k262", ch_s(0), 16320);
        chk("mix_k262", mix_s(), -16320);
        step(1);   chk("mix_k263", mix_s(), 16320);
        step(10);  chk("div_k273", ch_s(0), -16320);

        // Retrigger 9 -> 19 in the negative half
        set_div(0, 19);
        step(1);   chk("retrig_r1", ch_s(0), -16320);
        step(1);   chk("retrig_r2", ch_s(0), 16320);
        step(19);  chk("retrig_r21", ch_s(0), 16320);
        step(1);   chk("retrig_r22", ch_s(0), -16320);

        // Rest: the change to div=1 restarts at positive phase, then gain ramps down
        set_div(0, 1);
        step(1);   chk("rest_s1", ch_s(0), -16320);
        step(1);   chk("rest_s2", ch_s(0), 16256);
        step(98);  chk("rest_s100", ch_s(0), 9984);
        step(155); chk("rest_s255", ch_s(0), 64);
        step(1);   chk("rest_s256", ch_s(0), 0);
        step(20);  chk("rest_s276", ch_s(0), 0);

        // Mix saturation, four channels in phase
        for (int c = 0; c < 4; c++) set_div(c, 9);
        step(12);  chk("sat_ch1_k12", ch_s(1), -704);
        step(1);   chk("sat_mix_k13", mix_s(), -2816);
        step(248); chk("sat_mix_low", mix_s(), -32768);
        step(1);   chk("sat_ch2_k262", ch_s(2), 16320);
        step(1);   chk("sat_mix_high", mix_s(), 32767);

        // Lower volume levels while playing
        for (int i = 0; i < 4; i++) pulse_down();
        chk("vol_level1", 32'(volume), 1);
        step(2);
        mag = ch_s(0);
        if (mag < 0) mag = -mag;
        chk("ch0_vol1_mag", mag, 1020);
        mag = mix_s();
        if (mag < 0) mag = -mag;
        chk("mix_vol1_mag", mag, 4080);
        pulse_down();
        step(2);
        chk("mute_ch0", ch_s(0), 0);
        chk("mute_mix", mix_s(), 0);

        // Asynchronous reset mid-note
        #3 rst = 1'b1;
        #1;
        chk("arst_volume", 32'(volume), 3);
        chk("arst_ch0", ch_s(0), 0);
        chk("arst_ch2", ch_s(2), 0);
        chk("arst_mix", mix_s(), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1);   chk("post_k1", ch_s(0), 0);
        step(1);   chk("post_k2", ch_s(0), 16);
        step(1);   chk("post_k3", ch_s(0), 32);
        chk("post_mix_k3", mix_s(), 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
